// File: rtl/pwm_capture_apb_pkg.sv
// Shared constants and types for the servo PWM capture peripheral.
// Timing constants match the servo PWM generator at 100 MHz.
package pwm_capture_apb_pkg;

    localparam logic [31:0] PW_NEUTRAL      = 32'd150000;
    localparam logic [31:0] PW_FULL_FORWARD = 32'd200000;
    localparam logic [31:0] PW_FULL_REVERSE = 32'd100000;
    localparam logic [31:0] PW_TOL          = 32'd5000;
    localparam logic [31:0] TIMEOUT         = 32'd4000000;

    localparam logic [7:0] ADDR_PW     = 8'h00;
    localparam logic [7:0] ADDR_PERIOD = 8'h04;
    localparam logic [7:0] ADDR_STATUS = 8'h08;
    localparam logic [7:0] ADDR_CTRL   = 8'h0C;
    localparam logic [7:0] ADDR_COUNT  = 8'h10;

    localparam logic [31:0] UNMAPPED_DATA = 32'hFFFF_FFFF;

    localparam int STAT_VALID   = 0;
    localparam int STAT_NEW     = 1;
    localparam int STAT_TIMEOUT = 2;
    localparam int STAT_OOR     = 3;
    localparam int STAT_CLASS   = 4;

    typedef enum logic [1:0] {
        CLASS_NEUTRAL = 2'b00,
        CLASS_FORWARD = 2'b01,
        CLASS_REVERSE = 2'b10,
        CLASS_NONE    = 2'b11
    } pwm_class_t;

    typedef enum logic [1:0] {
        MEAS_IDLE = 2'b00,
        MEAS_HIGH = 2'b01,
        MEAS_LOW  = 2'b10
    } meas_state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pwm_capture_apb_if.sv
// APB3 completer-side bus bundle for the PWM capture peripheral.
interface pwm_capture_apb_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/pwm_capture_apb_pwm_measure.sv
// Synchronises the PWM input and measures high time and rise-to-rise period.
// Emits a single-cycle commit (with pw/period) or timeout strobe.
module pwm_capture_apb_pwm_measure
    import pwm_capture_apb_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_LIM = TIMEOUT
) (
    input  logic        PCLK,
    input  logic        PRESERN,
    input  logic        enable,
    input  logic        pwm_in,
    output logic        commit,
    output logic        timeout,
    output logic [31:0] pw,
    output logic [31:0] period
);

    logic        sync1_reg, sync2_reg, prev_reg;
    logic        rise, fall;
    meas_state_t state_reg, state_next;
    logic [31:0] hi_cnt_reg, hi_cnt_next;
    logic [31:0] per_cnt_reg, per_cnt_next;
    logic [31:0] idle_cnt_reg, idle_cnt_next;

    assign rise   = sync2_reg & ~prev_reg;
    assign fall   = ~sync2_reg & prev_reg;
    assign pw     = hi_cnt_reg;
    assign period = per_cnt_reg;

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            sync1_reg    <= 1'b0;
            sync2_reg    <= 1'b0;
            prev_reg     <= 1'b0;
            state_reg    <= MEAS_IDLE;
            hi_cnt_reg   <= '0;
            per_cnt_reg  <= '0;
            idle_cnt_reg <= '0;
        end else begin
            sync1_reg    <= pwm_in;
            sync2_reg    <= sync1_reg;
            prev_reg     <= sync2_reg;
            state_reg    <= state_next;
            hi_cnt_reg   <= hi_cnt_next;
            per_cnt_reg  <= per_cnt_next;
            idle_cnt_reg <= idle_cnt_next;
        end
    end

    // The fall cycle is excluded from hi_cnt so it equals the synchronised high time.
    always_comb begin
        state_next    = state_reg;
        hi_cnt_next   = hi_cnt_reg;
        per_cnt_next  = per_cnt_reg;
        idle_cnt_next = idle_cnt_reg;
        commit        = 1'b0;
        timeout       = 1'b0;
        if (!enable) begin
            state_next    = MEAS_IDLE;
            hi_cnt_next   = '0;
            per_cnt_next  = '0;
            idle_cnt_next = '0;
        end else begin
            case (state_reg)
                MEAS_IDLE: begin
                    if (rise) begin
                        state_next    = MEAS_HIGH;
                        hi_cnt_next   = 32'd1;
                        per_cnt_next  = 32'd1;
                        idle_cnt_next = '0;
                    end else if (idle_cnt_reg >= TIMEOUT_LIM) begin
                        timeout       = 1'b1;
                        idle_cnt_next = '0;
                    end else begin
                        idle_cnt_next = sat_inc(idle_cnt_reg);
                    end
                end
                MEAS_HIGH: begin
                    if (per_cnt_reg >= TIMEOUT_LIM) begin
                        timeout      = 1'b1;
                        state_next   = MEAS_IDLE;
                        hi_cnt_next  = '0;
                        per_cnt_next = '0;
                    end else begin
                        per_cnt_next = sat_inc(per_cnt_reg);
                        if (fall) state_next  = MEAS_LOW;
                        else      hi_cnt_next = sat_inc(hi_cnt_reg);
                    end
                end
                MEAS_LOW: begin
                    if (per_cnt_reg >= TIMEOUT_LIM) begin
                        timeout      = 1'b1;
                        state_next   = MEAS_IDLE;
                        hi_cnt_next  = '0;
                        per_cnt_next = '0;
                    end else if (rise) begin
                        commit       = 1'b1;
                        state_next   = MEAS_HIGH;
                        hi_cnt_next  = 32'd1;
                        per_cnt_next = 32'd1;
                    end else begin
                        per_cnt_next = sat_inc(per_cnt_reg);
                    end
                end
                default: state_next = MEAS_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/pwm_capture_apb.sv
// APB3 servo PWM capture: register file, classification and sample counter
// around the measurement core.
module pwm_capture_apb
    import pwm_capture_apb_pkg::*;
#(
    parameter logic [31:0] NEUTRAL_W   = PW_NEUTRAL,
    parameter logic [31:0] FORWARD_W   = PW_FULL_FORWARD,
    parameter logic [31:0] REVERSE_W   = PW_FULL_REVERSE,
    parameter logic [31:0] TOL_W       = PW_TOL,
    parameter logic [31:0] TIMEOUT_LIM = TIMEOUT
) (
    input  logic             PCLK,
    input  logic             PRESERN,
    input  logic             pwm_in,
    pwm_capture_apb_if.slave apb
);

    // Index equals the class encoding: neutral, forward, reverse.
    localparam logic [2:0][31:0] NOMINAL = {REVERSE_W, FORWARD_W, NEUTRAL_W};

    logic        meas_commit, meas_timeout;
    logic [31:0] meas_pw, meas_period;

    logic [31:0] pw_reg, period_reg, count_reg, prdata_reg;
    logic        valid_reg, new_reg, timeout_reg, oor_reg, enable_reg;
    pwm_class_t  class_reg, class_next;
    logic        oor_next;
    logic [2:0]  in_band;
    logic [31:0] status_word, rd_data;
    logic [7:0]  addr;
    logic        rd_setup, wr_access;
    logic        unused_apb;

    pwm_capture_apb_pwm_measure #(
        .TIMEOUT_LIM(TIMEOUT_LIM)
    ) u_measure (
        .PCLK    (PCLK),
        .PRESERN (PRESERN),
        .enable  (enable_reg),
        .pwm_in  (pwm_in),
        .commit  (meas_commit),
        .timeout (meas_timeout),
        .pw      (meas_pw),
        .period  (meas_period)
    );

    assign addr        = apb.PADDR[7:0];
    assign rd_setup    = apb.PSEL & ~apb.PENABLE & ~apb.PWRITE;
    assign wr_access   = apb.PSEL & apb.PENABLE & apb.PWRITE;
    assign apb.PRDATA  = prdata_reg;
    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = 1'b0;
    assign unused_apb  = ^{apb.PADDR[31:8], apb.PWDATA[31:1]};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_band
            logic [31:0] diff;
            assign diff        = (meas_pw >= NOMINAL[gi]) ? (meas_pw - NOMINAL[gi])
                                                          : (NOMINAL[gi] - meas_pw);
            assign in_band[gi] = (diff <= TOL_W);
        end
    endgenerate

    always_comb begin
        class_next = CLASS_NONE;
        if (in_band[0])      class_next = CLASS_NEUTRAL;
        else if (in_band[1]) class_next = CLASS_FORWARD;
        else if (in_band[2]) class_next = CLASS_REVERSE;
        oor_next = (meas_pw < (REVERSE_W - TOL_W)) || (meas_pw > (FORWARD_W + TOL_W));
    end

    always_comb begin
        status_word                     = '0;
        status_word[STAT_VALID]         = valid_reg;
        status_word[STAT_NEW]           = new_reg;
        status_word[STAT_TIMEOUT]       = timeout_reg;
        status_word[STAT_OOR]           = oor_reg;
        status_word[STAT_CLASS +: 2]    = class_reg;
    end

    always_comb begin
        rd_data = UNMAPPED_DATA;
        case (addr)
            ADDR_PW:     rd_data = pw_reg;
            ADDR_PERIOD: rd_data = period_reg;
            ADDR_STATUS: rd_data = status_word;
            ADDR_CTRL:   rd_data = {31'd0, enable_reg};
            ADDR_COUNT:  rd_data = count_reg;
            default:     rd_data = UNMAPPED_DATA;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            prdata_reg  <= '0;
            pw_reg      <= '0;
            period_reg  <= '0;
            count_reg   <= '0;
            valid_reg   <= 1'b0;
            new_reg     <= 1'b0;
            timeout_reg <= 1'b0;
            oor_reg     <= 1'b0;
            class_reg   <= CLASS_NONE;
            enable_reg  <= 1'b0;
        end else begin
            if (rd_setup) prdata_reg <= rd_data;
            if (wr_access && addr == ADDR_CTRL) enable_reg <= apb.PWDATA[0];

            if (meas_commit) begin
                pw_reg      <= meas_pw;
                period_reg  <= meas_period;
                count_reg   <= count_reg + 32'd1;
                valid_reg   <= 1'b1;
                timeout_reg <= 1'b0;
                oor_reg     <= oor_next;
                class_reg   <= class_next;
            end else if (meas_timeout) begin
                valid_reg   <= 1'b0;
                timeout_reg <= 1'b1;
                class_reg   <= CLASS_NONE;
            end

            // A commit coinciding with a STATUS read keeps new set.
            if (meas_commit)                         new_reg <= 1'b1;
            else if (rd_setup && addr == ADDR_STATUS) new_reg <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pwm_capture_apb.sv
// Scoreboard bench for pwm_capture_apb with scaled-down timing constants.
module tb_pwm_capture_apb;
    import pwm_capture_apb_pkg::*;

    localparam int NEU = 150;
    localparam int FWD = 200;
    localparam int REV = 100;
    localparam int TOL = 5;
    localparam int TO  = 4000;

    logic PCLK    = 1'b0;
    logic PRESERN = 1'b0;
    logic pwm_in  = 1'b0;

    pwm_capture_apb_if apb();

    pwm_capture_apb #(
        .NEUTRAL_W   (32'(NEU)),
        .FORWARD_W   (32'(FWD)),
        .REVERSE_W   (32'(REV)),
        .TOL_W       (32'(TOL)),
        .TIMEOUT_LIM (32'(TO))
    ) dut (
        .PCLK    (PCLK),
        .PRESERN (PRESERN),
        .pwm_in  (pwm_in),
        .apb     (apb)
    );

    always #5 PCLK = ~PCLK;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];

    // Reference model of the register file, driven by the pulse train the bench issues.
    logic [31:0] m_pw, m_per, m_count;
    logic        m_valid, m_new, m_to, m_oor, m_en, m_armed;
    logic [1:0]  m_cls;
    int          prev_h, prev_total;

    function automatic int absdiff(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    function automatic logic [1:0] class_of(input int w);
        if (absdiff(w, NEU) <= TOL) return 2'b00;
        if (absdiff(w, FWD) <= TOL) return 2'b01;
        if (absdiff(w, REV) <= TOL) return 2'b10;
        return 2'b11;
    endfunction

    function automatic logic [31:0] model_status();
        return {26'd0, m_cls, m_oor, m_to, m_new, m_valid};
    endfunction

    task automatic model_reset();
        m_pw = 0; m_per = 0; m_count = 0;
        m_valid = 0; m_new = 0; m_to = 0; m_oor = 0; m_cls = 2'b11;
        m_en = 0; m_armed = 0; prev_h = 0; prev_total = 0;
    endtask

    // A raw rise ends the previous period: commit it, or report its timeout.
    task automatic model_rise(input int h, input int l);
        if (m_en) begin
            if (m_armed && prev_total < TO) begin
                m_pw = 32'(prev_h); m_per = 32'(prev_total);
                m_valid = 1; m_new = 1; m_to = 0; m_count = m_count + 1;
                m_cls = class_of(prev_h);
                m_oor = (prev_h < REV - TOL) || (prev_h > FWD + TOL);
            end else if (m_armed) begin
                m_to = 1; m_valid = 0; m_cls = 2'b11;
            end
            m_armed = 1; prev_h = h; prev_total = h + l;
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge PCLK);
            #1;
        end
    endtask

    task automatic apb_read(input logic [7:0] addr, input string nm, input logic [31:0] expv);
        exp_q.push_back(expv);
        name_q.push_back(nm);
        apb.PADDR   = ($urandom() & 32'hFFFF_FF00) | {24'd0, addr};
        apb.PWRITE  = 1'b0;
        apb.PSEL    = 1'b1;
        apb.PENABLE = 1'b0;
        wait_cyc(1);
        apb.PENABLE = 1'b1;
        wait_cyc(1);
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
    endtask

    task automatic apb_write(input logic [7:0] addr, input logic [31:0] data);
        apb.PADDR   = ($urandom() & 32'hFFFF_FF00) | {24'd0, addr};
        apb.PWDATA  = data;
        apb.PWRITE  = 1'b1;
        apb.PSEL    = 1'b1;
        apb.PENABLE = 1'b0;
        wait_cyc(1);
        apb.PENABLE = 1'b1;
        wait_cyc(1);
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = 1'b0;
    endtask

    task automatic set_enable(input logic en);
        apb_write(ADDR_CTRL, ($urandom() & 32'hFFFF_FFFE) | {31'd0, en});
        m_en = en;
        if (!en) m_armed = 0;
    endtask

    task automatic check_regs();
        apb_read(ADDR_PW,     "pw",     m_pw);
        apb_read(ADDR_PERIOD, "period", m_per);
        apb_read(ADDR_STATUS, "status", model_status());
        m_new = 0;
        apb_read(ADDR_COUNT,  "count",  m_count);
    endtask

    task automatic send_period(input int h, input int l, input bit do_check);
        int used;
        pwm_in = 1'b1;
        model_rise(h, l);
        wait_cyc(8);
        used = 8;
        if (do_check) begin
            check_regs();
            used += 8;
        end
        wait_cyc(h - used);
        pwm_in = 1'b0;
        wait_cyc(l);
    endtask

    // STATUS setup phase lands on the commit edge (third edge after the raw rise).
    task automatic send_race_period(input int h, input int l);
        pwm_in = 1'b1;
        wait_cyc(2);
        apb_read(ADDR_STATUS, "race_pre", model_status());
        model_rise(h, l);
        wait_cyc(4);
        apb_read(ADDR_STATUS, "race_second", model_status());
        m_new = 0;
        apb_read(ADDR_STATUS, "race_third", model_status());
        wait_cyc(h - 12);
        pwm_in = 1'b0;
        wait_cyc(l);
    endtask

    task automatic check_prdata_zero(input string nm);
        checks++;
        if (apb.PRDATA !== 32'h0) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, apb.PRDATA, 32'h0);
        end
    endtask

    always @(negedge PCLK) begin : monitor
        logic [31:0] e;
        string       n;
        if (apb.PSEL && apb.PENABLE && !apb.PWRITE && apb.PREADY) begin
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_read actual=%h required=no_read", apb.PRDATA);
            end else begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                checks++;
                if (apb.PRDATA !== e) begin
                    errors++;
                    $display("FAIL %s actual=%h required=%h", n, apb.PRDATA, e);
                end else begin
                    $display("read %-12s addr=%h data=%h", n, apb.PADDR[7:0], apb.PRDATA);
                end
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        int widths [5];
        int bnd [8];
        int h, l, used;

        apb.PSEL = 0; apb.PENABLE = 0; apb.PWRITE = 0; apb.PADDR = 0; apb.PWDATA = 0;
        model_reset();
        wait_cyc(2);
        check_prdata_zero("reset_prdata");
        PRESERN = 1'b1;
        wait_cyc(2);

        apb_read(ADDR_PW,     "rst_pw",     32'h0);
        apb_read(ADDR_PERIOD, "rst_period", 32'h0);
        apb_read(ADDR_STATUS, "rst_status", 32'h30);
        apb_read(ADDR_CTRL,   "rst_ctrl",   32'h0);
        apb_read(ADDR_COUNT,  "rst_count",  32'h0);

        set_enable(1'b1);
        apb_read(ADDR_CTRL, "ctrl_on", 32'h1);
        wait_cyc(10);

        // Nominal neutral train
        repeat (3) send_period(150, 1850, 1);
        send_period(150, 1850, 1);

        // Forward, reverse, in-between and out-of-range widths
        widths = '{200, 100, 175, 50, 150};
        foreach (widths[i]) send_period(widths[i], 2000 - widths[i], 1);
        send_period(150, 1850, 1);

        // Timeout during the low phase, then two full periods recover
        send_period(150, 4300, 1);
        send_period(150, 1850, 1);
        send_period(150, 1850, 1);
        send_period(150, 1850, 1);

        // Commit racing a STATUS read
        send_period(150, 1850, 1);
        send_race_period(150, 1850);
        send_period(150, 1850, 1);

        // Disable mid-high, re-enable while still high
        pwm_in = 1'b1;
        model_rise(150, 1850);
        wait_cyc(20);
        set_enable(1'b0);
        apb_read(ADDR_CTRL, "ctrl_off", 32'h0);
        wait_cyc(26);
        set_enable(1'b1);
        wait_cyc(150 - 52);
        pwm_in = 1'b0;
        wait_cyc(1850);
        send_period(160, 1840, 1);
        send_period(170, 1830, 1);
        send_period(150, 1850, 1);

        // Classification boundaries, then random widths and periods
        bnd = '{NEU - TOL, NEU + TOL, NEU + TOL + 1, FWD + TOL,
                FWD + TOL + 1, REV - TOL, REV - TOL - 1, NEU - TOL - 1};
        foreach (bnd[i]) send_period(bnd[i], 2000 - bnd[i], 1);
        repeat (8) begin
            h = $urandom_range(60, 260);
            l = 1500 + $urandom_range(0, 800) - h;
            send_period(h, l, 1);
        end

        // Writes to read-only offsets and unmapped reads
        pwm_in = 1'b1;
        model_rise(150, 1850);
        wait_cyc(8);
        apb_write(ADDR_PW,     $urandom());
        apb_write(ADDR_PERIOD, $urandom());
        apb_write(ADDR_STATUS, $urandom());
        apb_write(ADDR_COUNT,  $urandom());
        apb_read(8'h20, "unmapped_20", 32'hFFFF_FFFF);
        apb_read(8'($urandom_range(8'h14, 8'hFF)), "unmapped_rnd", 32'hFFFF_FFFF);
        check_regs();
        apb_read(ADDR_CTRL, "ctrl", {31'd0, m_en});
        wait_cyc(150 - 30);
        pwm_in = 1'b0;
        wait_cyc(1850);

        // Asynchronous reset in the middle of a high phase
        pwm_in = 1'b1;
        model_rise(150, 1850);
        wait_cyc(20);
        PRESERN = 1'b0;
        #2;
        check_prdata_zero("async_rst_prdata");
        wait_cyc(2);
        PRESERN = 1'b1;
        model_reset();
        check_regs();
        apb_read(ADDR_CTRL, "rst_ctrl2", 32'h0);
        used = 32;
        wait_cyc(150 - used);
        pwm_in = 1'b0;
        wait_cyc(100);
        set_enable(1'b1);
        wait_cyc(1850 - 102);
        repeat (3) send_period(150, 1850, 1);

        wait_cyc(4);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_reads actual=%0d required=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
